// File: rtl/ex_mem_ctl_if.sv
// EX/MEM boundary bundle: EX-side fields, pipeline controls, registered MEM-side fields and EX feedback.
// Carries no state or latency of its own. The timing is set by the register stage attached to it.
// Backpressure is by level only: stall_ex, stall_mem and flush are sampled on each edge, with no handshake.
// Ports (modports):
//   master - driven by the EX stage and controller. It drives ex_*, stall_*, flush and reads mem_* and feedback.
//   slave  - the EX/MEM register. It reads ex_* and the controls, and drives mem_*, cnt_o, hilo_temp_o and stall_cycles.
interface ex_mem_ctl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LANES  = 1,
    parameter int OP_W   = 8,
    parameter int CNT_W  = 2,
    parameter int PERF_W = 16
) ();
    // pipeline controller
    logic                      stall_ex;
    logic                      stall_mem;
    logic                      flush;

    // EX side
    logic                      ex_valid;
    logic [LANES*ADDR_W-1:0]   ex_wd;
    logic [LANES-1:0]          ex_wreg;
    logic [LANES*DATA_W-1:0]   ex_wdata;
    logic                      ex_whilo;
    logic [DATA_W-1:0]         ex_hi;
    logic [DATA_W-1:0]         ex_lo;
    logic [OP_W-1:0]           ex_mem_op;
    logic [DATA_W-1:0]         ex_mem_addr;
    logic [DATA_W-1:0]         ex_mem_sdata;
    logic [CNT_W-1:0]          ex_cnt;
    logic [2*DATA_W-1:0]       ex_hilo_temp;

    // MEM side
    logic                      mem_valid;
    logic [LANES*ADDR_W-1:0]   mem_wd;
    logic [LANES-1:0]          mem_wreg;
    logic [LANES*DATA_W-1:0]   mem_wdata;
    logic                      mem_whilo;
    logic [DATA_W-1:0]         mem_hi;
    logic [DATA_W-1:0]         mem_lo;
    logic [OP_W-1:0]           mem_mem_op;
    logic [DATA_W-1:0]         mem_mem_addr;
    logic [DATA_W-1:0]         mem_mem_sdata;

    // feedback to EX and perf
    logic [CNT_W-1:0]          cnt_o;
    logic [2*DATA_W-1:0]       hilo_temp_o;
    logic [PERF_W-1:0]         stall_cycles;

    modport master (
        output stall_ex, stall_mem, flush,
        output ex_valid, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo,
        output ex_mem_op, ex_mem_addr, ex_mem_sdata, ex_cnt, ex_hilo_temp,
        input  mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
        input  mem_mem_op, mem_mem_addr, mem_mem_sdata,
        input  cnt_o, hilo_temp_o, stall_cycles
    );

    modport slave (
        input  stall_ex, stall_mem, flush,
        input  ex_valid, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo,
        input  ex_mem_op, ex_mem_addr, ex_mem_sdata, ex_cnt, ex_hilo_temp,
        output mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
        output mem_mem_op, mem_mem_addr, mem_mem_sdata,
        output cnt_o, hilo_temp_o, stall_cycles
    );
endinterface

// File: rtl/ex_mem_ctl.sv
// EX/MEM pipeline register with hold, bubble and flush, the multi-cycle feedback path, and a stall-cycle counter.
// Latency is 1 cycle from ex_* to mem_* on an advancing edge.
// Backpressure: stall_mem holds the stage. stall_ex alone inserts a bubble. flush kills the stage and has priority.
// Ports:
//   clk - rising-edge clock for all state.
//   rst - synchronous, active-high. It clears every output.
//   bus - ex_mem_ctl_if.slave. It carries ex_* in, mem_* out, the controls, cnt_o/hilo_temp_o feedback and stall_cycles.
module ex_mem_ctl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LANES  = 1,
    parameter int OP_W   = 8,
    parameter int CNT_W  = 2,
    parameter int PERF_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    ex_mem_ctl_if.slave   bus
);

    typedef struct packed {
        logic                    valid;
        logic [LANES*ADDR_W-1:0] wd;
        logic [LANES-1:0]        wreg;
        logic [LANES*DATA_W-1:0] wdata;
        logic                    whilo;
        logic [DATA_W-1:0]       hi;
        logic [DATA_W-1:0]       lo;
        logic [OP_W-1:0]         mem_op;
        logic [DATA_W-1:0]       mem_addr;
        logic [DATA_W-1:0]       mem_sdata;
    } stage_t;

    // A stall bubble and a flush both produce an empty stage. They are kept as
    // separate actions because only the stall bubble counts as a lost cycle.
    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_HOLD    = 2'd1,
        ACT_BUBBLE  = 2'd2,
        ACT_FLUSH   = 2'd3
    } act_t;

    act_t              act;
    stage_t            ex_stage;
    stage_t            stage_d;
    stage_t            stage_q;

    logic              fb_busy;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*DATA_W-1:0] hilo_d;
    logic [2*DATA_W-1:0] hilo_q;

    logic              perf_inc;
    logic              perf_sat;
    logic [PERF_W-1:0] perf_q;

    // Gather the EX-side fields into one record.
    always_comb begin
        ex_stage           = '0;
        ex_stage.valid     = bus.ex_valid;
        ex_stage.wd        = bus.ex_wd;
        ex_stage.wreg      = bus.ex_wreg;
        ex_stage.wdata     = bus.ex_wdata;
        ex_stage.whilo     = bus.ex_whilo;
        ex_stage.hi        = bus.ex_hi;
        ex_stage.lo        = bus.ex_lo;
        ex_stage.mem_op    = bus.ex_mem_op;
        ex_stage.mem_addr  = bus.ex_mem_addr;
        ex_stage.mem_sdata = bus.ex_mem_sdata;
    end

    // Action decode. A stall of EX alone must not let MEM see the held
    // instruction twice, so it becomes a bubble and not a hold.
    always_comb begin
        act = ACT_ADVANCE;
        if (bus.flush) begin
            act = ACT_FLUSH;
        end else if (bus.stall_ex && !bus.stall_mem) begin
            act = ACT_BUBBLE;
        end else if (bus.stall_mem) begin
            act = ACT_HOLD;
        end
    end

    // Next stage contents. Lanes are copied as one vector, and same-address
    // lanes are left for downstream to order.
    always_comb begin
        stage_d = stage_q;
        case (act)
            ACT_ADVANCE: stage_d = ex_stage;
            ACT_HOLD:    stage_d = stage_q;
            ACT_BUBBLE:  stage_d = '0;
            ACT_FLUSH:   stage_d = '0;
            default:     stage_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Multi-cycle feedback. While EX is stalled, the op is still iterating, so
    // its step and partial result go back around. A flush abandons the op.
    assign fb_busy = bus.stall_ex && !bus.flush;

    always_comb begin
        cnt_d  = '0;
        hilo_d = '0;
        if (fb_busy) begin
            cnt_d  = bus.ex_cnt;
            hilo_d = bus.ex_hilo_temp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            hilo_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            hilo_q <= hilo_d;
        end
    end

    // Stall-cycle counter. It counts stall bubbles and holds, and sticks at all-ones.
    assign perf_inc = (act == ACT_BUBBLE) || (act == ACT_HOLD);
    assign perf_sat = &perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (perf_inc && !perf_sat) begin
            perf_q <= perf_q + PERF_W'(1);
        end
    end

    assign bus.mem_valid     = stage_q.valid;
    assign bus.mem_wd        = stage_q.wd;
    assign bus.mem_wreg      = stage_q.wreg;
    assign bus.mem_wdata     = stage_q.wdata;
    assign bus.mem_whilo     = stage_q.whilo;
    assign bus.mem_hi        = stage_q.hi;
    assign bus.mem_lo        = stage_q.lo;
    assign bus.mem_mem_op    = stage_q.mem_op;
    assign bus.mem_mem_addr  = stage_q.mem_addr;
    assign bus.mem_mem_sdata = stage_q.mem_sdata;

    assign bus.cnt_o         = cnt_q;
    assign bus.hilo_temp_o   = hilo_q;
    assign bus.stall_cycles  = perf_q;

endmodule
